// File: rtl/nibble_compare_sequencer.sv
// nibble_compare_sequencer
//   Initiator side of a shared 4-bit comparator. It latches two WIDTH-bit unsigned operands and
//   presents them to the comparator one nibble at a time, MSB nibble first. It then folds the
//   per-nibble eq/lt/gt answers into a registered magnitude result.
//
//   Optional feature macro: EARLY_EXIT_EN
//     defined   - leave the scan on the edge that samples the first unequal nibble
//     undefined - always scan all N nibbles; result locked at the first unequal nibble
//
// Parameters
//   WIDTH    operand width, multiple of 4 and >= 4 (N = WIDTH/4 nibbles)
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start, a, b              compare request and operands (sampled in idle only)
//   busy, done               busy in compare/done states; done is a one-cycle pulse
//   eq, lt, gt               registered result, held until the next accepted start
//   cmp_a, cmp_b             registered nibbles driven to the external comparator
//   cmp_eq, cmp_lt, cmp_gt   same-cycle comparator response
module nibble_compare_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_gt
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_a, r_b, w_a_nxt, w_b_nxt;
  logic [IdxW-1:0]   r_idx, w_idx_nxt, w_idx_dec;
  logic              r_decided, w_decided_nxt;
  logic              r_eq, r_lt, r_gt, w_eq_nxt, w_lt_nxt, w_gt_nxt;
  logic [3:0]        r_cmp_a, r_cmp_b, w_cmp_a_nxt, w_cmp_b_nxt;

  // Comparator response decode: gt beats lt, lt beats eq, all-zero reads as eq.
  logic w_nib_gt, w_nib_lt, w_nib_eq, w_unequal, w_new_dec, w_last, w_leave;

  assign w_nib_gt  = cmp_gt;
  assign w_nib_lt  = cmp_lt & ~cmp_gt;
  assign w_nib_eq  = cmp_eq | ~(cmp_lt | cmp_gt);
  assign w_unequal = w_nib_gt | w_nib_lt;
  assign w_last    = (r_idx == '0);
  assign w_idx_dec = r_idx - 1'b1;
  assign w_new_dec = ~r_decided & w_unequal;

`ifdef EARLY_EXIT_EN
  assign w_leave = w_last | w_new_dec;
`else
  assign w_leave = w_last;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_idx_nxt     = r_idx;
    w_decided_nxt = r_decided;
    w_eq_nxt      = r_eq;
    w_lt_nxt      = r_lt;
    w_gt_nxt      = r_gt;
    w_cmp_a_nxt   = r_cmp_a;
    w_cmp_b_nxt   = r_cmp_b;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_a_nxt       = a;
          w_b_nxt       = b;
          w_idx_nxt     = IdxW'(N - 1);
          w_decided_nxt = 1'b0;
          w_eq_nxt      = 1'b0;
          w_lt_nxt      = 1'b0;
          w_gt_nxt      = 1'b0;
          w_cmp_a_nxt   = a[WIDTH-1 -: 4];
          w_cmp_b_nxt   = b[WIDTH-1 -: 4];
          w_state_nxt   = StCmp;
        end
      end
      StCmp: begin
        if (w_new_dec) begin
          w_lt_nxt      = w_nib_lt;
          w_gt_nxt      = w_nib_gt;
          w_decided_nxt = 1'b1;
        end else if (!r_decided && w_last && w_nib_eq) begin
          w_eq_nxt = 1'b1;
        end
        if (w_leave) begin
          // Comparator inputs hold their last nibble; the next nibble is never presented.
          w_state_nxt = StDone;
        end else begin
          w_idx_nxt   = w_idx_dec;
          w_cmp_a_nxt = r_a[{w_idx_dec, 2'b00} +: 4];
          w_cmp_b_nxt = r_b[{w_idx_dec, 2'b00} +: 4];
        end
      end
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= IdxW'(N - 1);
      r_decided <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_gt      <= 1'b0;
      r_cmp_a   <= '0;
      r_cmp_b   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_idx     <= w_idx_nxt;
      r_decided <= w_decided_nxt;
      r_eq      <= w_eq_nxt;
      r_lt      <= w_lt_nxt;
      r_gt      <= w_gt_nxt;
      r_cmp_a   <= w_cmp_a_nxt;
      r_cmp_b   <= w_cmp_b_nxt;
    end
  end

  assign busy  = (r_state != StIdle);
  assign done  = (r_state == StDone);
  assign eq    = r_eq;
  assign lt    = r_lt;
  assign gt    = r_gt;
  assign cmp_a = r_cmp_a;
  assign cmp_b = r_cmp_b;

endmodule

// File: tb/tb_nibble_compare_sequencer.sv
// Bench for nibble_compare_sequencer (WIDTH=8). The comparator is modelled behaviourally, with
// modes for illegal responses. Expected results, latencies and nibble order come from integer
// arithmetic on the operands.
module tb_nibble_compare_sequencer;
  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, eq, lt, gt;
  logic [3:0]       cmp_a, cmp_b;
  logic             cmp_eq, cmp_lt, cmp_gt;
  int               mode;  // 0 normal, 1 lt+gt both high, 2 all-zero response

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] log_a [16];
  logic [3:0] log_b [16];
  int         log_n;

  always #5 clk = ~clk;

  always_comb begin
    cmp_eq = 1'b0;
    cmp_lt = 1'b0;
    cmp_gt = 1'b0;
    case (mode)
      1: begin cmp_lt = 1'b1; cmp_gt = 1'b1; end
      2: ;
      default: begin
        cmp_eq = (cmp_a == cmp_b);
        cmp_lt = (cmp_a <  cmp_b);
        cmp_gt = (cmp_a >  cmp_b);
      end
    endcase
  end

  nibble_compare_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt)
  );

  // Drive a start pulse; returns at the negedge just after the accepting edge (edge 0).
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  // Log presented nibbles each busy cycle until done; edges = edge index of done, -1 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    log_n = 0;
    while (edges < 20 && !done) begin
      if (busy && log_n < 16) begin
        log_a[log_n] = cmp_a;
        log_b[log_n] = cmp_b;
        log_n++;
      end
      @(negedge clk);
      edges++;
    end
    if (!done) edges = -1;
  endtask

  task automatic test_compare(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input int m, input string name);
    int e, k, exp_e;
    logic [2:0] exp_r;  // {eq, lt, gt}
    mode = m;
    k = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (((av >> (4 * i)) & 15) != ((bv >> (4 * i)) & 15)) begin
        k = N - i;
        break;
      end
    end
    if (m == 1) begin
      exp_r = 3'b001; k = 1;
    end else if (m == 2) begin
      exp_r = 3'b100; k = N;
    end else begin
      exp_r = {av == bv, av < bv, av > bv};
    end
`ifdef EARLY_EXIT_EN
    exp_e = k;
`else
    exp_e = N;
`endif
    start_op(av, bv);
    wait_done(e);
    n_cmp++;
    if (e !== exp_e) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, e, exp_e);
    end
    n_cmp++;
    if ({eq, lt, gt} !== exp_r) begin
      n_fail++;
      $display("FAIL %s result eq/lt/gt: got %b, want %b", name, {eq, lt, gt}, exp_r);
    end
    n_cmp++;
    if (log_n !== exp_e) begin
      n_fail++;
      $display("FAIL %s nibbles presented: got %0d, want %0d", name, log_n, exp_e);
    end
    for (int i = 0; i < log_n && i < exp_e; i++) begin
      n_cmp++;
      if (log_a[i] !== 4'((av >> (4 * (N - 1 - i))) & 15) ||
          log_b[i] !== 4'((bv >> (4 * (N - 1 - i))) & 15)) begin
        n_fail++;
        $display("FAIL %s nibble %0d: got %h/%h, want %h/%h", name, i, log_a[i], log_b[i],
                 4'((av >> (4 * (N - 1 - i))) & 15), 4'((bv >> (4 * (N - 1 - i))) & 15));
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, eq, lt, gt} !== {2'b00, exp_r}) begin
      n_fail++;
      $display("FAIL %s after done busy/done/eq/lt/gt: got %b, want %b", name,
               {busy, done, eq, lt, gt}, {2'b00, exp_r});
    end
    mode = 0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, done, eq, lt, gt, cmp_a, cmp_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b, want 0", {busy, done, eq, lt, gt, cmp_a, cmp_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, eq, lt, gt} !== 5'd0) begin
      n_fail++;
      $display("FAIL idle after reset: got %b, want 0", {busy, done, eq, lt, gt});
    end
  endtask

  task automatic test_directed();
    test_compare(8'h5A, 8'h5A, 0, "eq_5A");
    test_compare(8'h3F, 8'h40, 0, "lt_3F_40");
    test_compare(8'h8F, 8'h81, 0, "gt_8F_81");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] av, bv;
    for (int i = 0; i < 30; i++) begin
      av = WIDTH'($urandom);
      bv = av;
      if ($urandom_range(0, 1) == 1) bv[3:0] = 4'($urandom);
      if ($urandom_range(0, 1) == 1) bv[7:4] = 4'($urandom);
      test_compare(av, bv, 0, "random");
    end
  endtask

  task automatic test_busy_ignore();
    int e, exp_e;
    mode = 0;
    start_op(8'h10, 8'h20);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef EARLY_EXIT_EN
    exp_e = 0;
`else
    exp_e = N - 1;
`endif
    wait_done(e);
    n_cmp++;
    if (e !== exp_e) begin
      n_fail++;
      $display("FAIL busy_ignore latency: got %0d, want %0d", e, exp_e);
    end
    n_cmp++;
    if ({eq, lt, gt} !== 3'b010) begin
      n_fail++;
      $display("FAIL busy_ignore result: got %b, want 010", {eq, lt, gt});
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore idle: got busy %b, want 0", busy);
    end
    test_compare(8'hFF, 8'h00, 0, "after_ignore");
  endtask

  task automatic test_back_to_back();
    int e;
    mode = 0;
    @(negedge clk);
    a = 8'h12; b = 8'h12; start = 1'b1;
    @(negedge clk);
    wait_done(e);
    n_cmp++;
    if (e !== N || eq !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b first: got edges %0d eq %b, want %0d 1", e, eq, N);
    end
    a = 8'h34; b = 8'h12;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b idle gap: got busy %b, want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b second accept: got busy %b, want 1", busy);
    end
    wait_done(e);
    n_cmp++;
    if ({eq, lt, gt} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b second result: got %b, want 001", {eq, lt, gt});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    test_compare(8'h44, 8'h33, 0, "pre_reset");
    start_op(8'h11, 8'h22);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, eq, lt, gt, cmp_a, cmp_b} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got %b, want 0", {busy, done, eq, lt, gt, cmp_a, cmp_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid activity: got %0d busy/done cycles, want 0", seen);
    end
    test_compare(8'h22, 8'h11, 0, "post_reset");
  endtask

  task automatic test_illegal();
    test_compare(8'h3F, 8'h40, 1, "lt_gt_both");
    test_compare(8'h3F, 8'h40, 2, "all_zero");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    mode = 0;
    #12;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
